// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit CPU datapath with RAM req/ack.
// Optional SEQ_SINGLE_STEP_EN adds i_step: FETCH exits once per rising edge of step.
module cpu_seq_ctrl #(
  parameter int OP_W    = 7,
  parameter int ALUOP_W = 3,
  parameter int TMO     = 15,
  parameter int CNT_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic               i_step,
`endif
  input  logic [OP_W-1:0]    i_opcode,
  input  logic               i_mem_ack,
  output logic               o_ir_load,
  output logic               o_pc_en,
  output logic               o_wr_en,
  output logic               o_wb_sel,
  output logic               o_mem_req,
  output logic               o_m_wr_en,
  output logic [ALUOP_W-1:0] o_alu_op,
  output logic [2:0]         o_state,
  output logic               o_halted,
  output logic               o_err,
  output logic [CNT_W-1:0]   o_instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_NOP   = 3'd0,
    C_ALU   = 3'd1,
    C_LOAD  = 3'd2,
    C_STORE = 3'd3,
    C_HALT  = 3'd4
  } cls_e;

  typedef struct packed {
    cls_e               cls;
    logic [ALUOP_W-1:0] alu_op;
  } dec_t;

  localparam logic [7:0] TMO_C = 8'(TMO);

  function automatic dec_t decode(input logic [OP_W-1:0] op);
    dec_t d;
    d.cls    = C_NOP;
    d.alu_op = '0;
    if (op >= OP_W'(1) && op <= OP_W'(7)) begin
      d.cls    = C_ALU;
      d.alu_op = ALUOP_W'(op - OP_W'(1));
    end else if (op == OP_W'(8)) begin
      d.cls    = C_LOAD;
      d.alu_op = ALUOP_W'(7);
    end else if (op == OP_W'(9)) begin
      d.cls    = C_STORE;
      d.alu_op = ALUOP_W'(7);
    end else if (op == OP_W'(10)) begin
      d.cls    = C_HALT;
    end
    return d;
  endfunction

  state_e             r_state;
  cls_e               r_cls;
  logic [ALUOP_W-1:0] r_alu_op;
  logic [7:0]         r_wcnt;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_run;
  logic               r_pc_en;
  logic               r_wr_en;
  logic               r_wb_sel;
  logic               r_mem_req;
  logic               r_m_wr_en;
  logic               w_go;
  dec_t               w_dec;

  assign w_dec = decode(i_opcode);

`ifdef SEQ_SINGLE_STEP_EN
  logic r_step_q;
  logic r_step_pend;

  // A step edge seen mid-instruction is remembered until the next FETCH consumes it.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_step_q    <= 1'b0;
      r_step_pend <= 1'b0;
    end else begin
      r_step_q <= i_step;
      if (i_step && !r_step_q)
        r_step_pend <= 1'b1;
      else if (r_state == S_FETCH && w_go)
        r_step_pend <= 1'b0;
    end
  end

  assign w_go = r_run & r_step_pend;
`else
  assign w_go = r_run;
`endif

  // run is registered so ir_load is a decode of flops only; back-to-back issue is unaffected.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= S_FETCH;
      r_cls     <= C_NOP;
      r_alu_op  <= '0;
      r_wcnt    <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_run     <= 1'b0;
      r_pc_en   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wb_sel  <= 1'b0;
      r_mem_req <= 1'b0;
      r_m_wr_en <= 1'b0;
    end else begin
      r_run     <= i_run;
      r_pc_en   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wb_sel  <= 1'b0;
      r_mem_req <= 1'b0;
      r_m_wr_en <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (w_go) r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_cls    <= w_dec.cls;
          r_alu_op <= w_dec.alu_op;
          r_state  <= (w_dec.cls == C_HALT) ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          r_wcnt <= '0;
          if (r_cls == C_LOAD || r_cls == C_STORE) begin
            r_state   <= S_MEM;
            r_mem_req <= 1'b1;
            r_m_wr_en <= (r_cls == C_STORE);
          end else begin
            r_state  <= S_WB;
            r_pc_en  <= 1'b1;
            r_wr_en  <= (r_cls == C_ALU);
          end
        end
        S_MEM: begin
          // An ack on the last allowed cycle still completes the access.
          if (i_mem_ack) begin
            r_state  <= S_WB;
            r_pc_en  <= 1'b1;
            r_wr_en  <= (r_cls == C_LOAD);
            r_wb_sel <= (r_cls == C_LOAD);
          end else if (r_wcnt + 8'd1 == TMO_C) begin
            r_err   <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_wcnt    <= r_wcnt + 8'd1;
            r_mem_req <= 1'b1;
            r_m_wr_en <= (r_cls == C_STORE);
          end
        end
        S_WB: begin
          r_cnt   <= r_cnt + CNT_W'(1);
          r_state <= S_FETCH;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  assign o_ir_load   = (r_state == S_FETCH) & w_go;
  assign o_pc_en     = r_pc_en;
  assign o_wr_en     = r_wr_en;
  assign o_wb_sel    = r_wb_sel;
  assign o_mem_req   = r_mem_req;
  assign o_m_wr_en   = r_m_wr_en;
  assign o_alu_op    = r_alu_op;
  assign o_state     = r_state;
  assign o_halted    = (r_state == S_HALT);
  assign o_err       = r_err;
  assign o_instr_cnt = r_cnt;

endmodule
